fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of the 8-entry byte FIFO (wr/wdata/full) between NREQ byte producers, e.g. the UART RX path and local command sources feeding the TX FIFO. It runs a valid/ready handshake with each producer, moves at most one byte per cycle into the FIFO and never writes while the FIFO reports full. An optional burst-lock mode lets one producer keep the port for a bounded run of consecutive bytes.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port between NREQ byte producers.
// Define ARB_BURST_LOCK_EN to let a granted producer hold the port for up to MAX_BURST bytes.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [8*NREQ-1:0]       req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic                    fifo_full_i,
    output logic                    fifo_wr_o,
    output logic [7:0]              fifo_wdata_o,
    output logic [$clog2(NREQ)-1:0] grant_id_o,
    output logic                    busy_o
);

    localparam int unsigned IdxW = $clog2(NREQ);
    typedef logic [IdxW-1:0] idx_t;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
        $error("MAX_BURST must be in 1..16");
    end

    // Explicit wrap keeps rr_ptr below NREQ when NREQ is not a power of two.
    function automatic idx_t next_idx(input idx_t i);
        return (int'(i) == int'(NREQ) - 1) ? '0 : i + idx_t'(1);
    endfunction

    idx_t rr_ptr_q;
    idx_t sel;
    logic sel_vld;
    logic locked;
    logic xfer;

`ifdef ARB_BURST_LOCK_EN
    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e     state_q;
    idx_t       owner_q;
    logic [3:0] burst_cnt_q;
    logic [4:0] burst_cnt_inc;

    assign locked        = (state_q == StLock);
    assign burst_cnt_inc = {1'b0, burst_cnt_q} + 5'd1;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
`ifdef ARB_BURST_LOCK_EN
        if (locked) begin
            sel     = owner_q;
            sel_vld = req_valid_i[owner_q];
        end else begin
`else
        begin
`endif
            // Descending scan so the lowest rotation offset from rr_ptr wins.
            for (int k = int'(NREQ) - 1; k >= 0; k--) begin
                int idx;
                idx = int'(rr_ptr_q) + k;
                if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
                if (req_valid_i[idx]) begin
                    sel     = idx_t'(idx);
                    sel_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (sel_vld && !fifo_full_i && !rst) req_ready_o[sel] = 1'b1;
        xfer         = |(req_valid_i & req_ready_o);
        fifo_wr_o    = xfer;
        fifo_wdata_o = xfer ? req_data_i[{sel, 3'b000} +: 8] : 8'h00;
        grant_id_o   = rst ? '0 : sel;
        busy_o       = locked;
    end

`ifdef ARB_BURST_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        if (MAX_BURST > 1) begin
                            owner_q     <= sel;
                            burst_cnt_q <= 4'd1;
                            state_q     <= StLock;
                        end else begin
                            rr_ptr_q <= next_idx(sel);
                        end
                    end
                end
                StLock: begin
                    // A full FIFO freezes the burst regardless of the owner's valid.
                    if (!fifo_full_i) begin
                        if (!req_valid_i[owner_q]) begin
                            rr_ptr_q    <= next_idx(owner_q);
                            burst_cnt_q <= '0;
                            state_q     <= StIdle;
                        end else if (burst_cnt_inc == 5'(MAX_BURST)) begin
                            rr_ptr_q    <= next_idx(owner_q);
                            burst_cnt_q <= '0;
                            state_q     <= StIdle;
                        end else begin
                            burst_cnt_q <= burst_cnt_inc[3:0];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (xfer) begin
            rr_ptr_q <= next_idx(sel);
        end
    end
`endif

endmodule
